zet_bus_arb: RTL



---
 rtl/zet_bus_arb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/zet_bus_arb.sv
// Fetch/exec arbiter for the shared 16-bit Wishbone master.
// Splits odd word accesses into two aligned bus cycles.
module zet_bus_arb #(
  parameter int unsigned MAX_EXEC_RUN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [19:0] f_adr,
  input  logic        f_byte,
  output logic [15:0] f_dat,
  output logic        f_ack,
  input  logic        e_req,
  input  logic        e_we,
  input  logic [19:0] e_adr,
  input  logic        e_byte,
  input  logic [15:0] e_wdat,
  output logic [15:0] e_rdat,
  output logic        e_ack,
  output logic [18:0] wb_adr_o,
  output logic [1:0]  wb_sel_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    ACK
  } state_t;

  typedef enum logic [1:0] {
    G_NONE,
    G_F,
    G_E
  } gnt_t;

  state_t      state;
  state_t      state_nx;
  gnt_t        gnt;
  logic [19:0] adr;
  logic        bsz;
  logic        we;
  logic [15:0] wdat;
  logic [15:0] rdat;
  logic [3:0]  run;
  logic        cyc;
  logic        pick_e;
  logic        pick_f;
  logic        split;
  logic        hi_ph;
  logic        bus_ack;

  assign pick_e  = e_req && (!f_req || run != 4'(MAX_EXEC_RUN));
  assign pick_f  = f_req && !pick_e;
  assign split   = adr[0] && !bsz;
  assign hi_ph   = state == HI;
  assign bus_ack = cyc && wb_ack_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (f_req || e_req) state_nx = LO;
      LO:   if (bus_ack) state_nx = split ? HI : ACK;
      HI:   if (bus_ack) state_nx = ACK;
      ACK:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt    <= G_NONE;
      adr    <= '0;
      bsz    <= 1'b0;
      we     <= 1'b0;
      wdat   <= '0;
      rdat   <= '0;
      cyc    <= 1'b0;
      f_ack  <= 1'b0;
      e_ack  <= 1'b0;
      f_dat  <= '0;
      e_rdat <= '0;
    end else begin
      f_ack <= 1'b0;
      e_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_e || pick_f) begin
            gnt  <= pick_e ? G_E : G_F;
            adr  <= pick_e ? e_adr : f_adr;
            bsz  <= pick_e ? e_byte : f_byte;
            we   <= pick_e && e_we;
            wdat <= pick_e ? e_wdat : 16'h0000;
            cyc  <= 1'b1;
          end
        end
        LO: begin
          if (bus_ack) begin
            cyc <= 1'b0;
            if (bsz)
              rdat <= {8'h00, adr[0] ? wb_dat_i[15:8] : wb_dat_i[7:0]};
            else if (adr[0])
              rdat[7:0] <= wb_dat_i[15:8];
            else
              rdat <= wb_dat_i;
          end
        end
        HI: begin
          // first HI cycle is the idle gap between the two transfers
          if (!cyc) begin
            cyc <= 1'b1;
          end else if (wb_ack_i) begin
            cyc        <= 1'b0;
            rdat[15:8] <= wb_dat_i[7:0];
          end
        end
        ACK: begin
          f_ack <= gnt == G_F;
          e_ack <= gnt == G_E;
          if (gnt == G_F) f_dat <= rdat;
          if (gnt == G_E) e_rdat <= rdat;
          gnt <= G_NONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run <= '0;
    end else if (!f_req) begin
      run <= '0;
    end else if (state == IDLE) begin
      if (pick_f)      run <= '0;
      else if (pick_e) run <= run + 4'd1;
    end
  end

  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;
  assign wb_we_o  = cyc && we;

  always_comb begin
    wb_adr_o = '0;
    wb_sel_o = 2'b00;
    wb_dat_o = '0;
    if (cyc) begin
      wb_adr_o = hi_ph ? adr[19:1] + 19'd1 : adr[19:1];
      if (hi_ph)       wb_sel_o = 2'b01;
      else if (adr[0]) wb_sel_o = 2'b10;
      else if (bsz)    wb_sel_o = 2'b01;
      else             wb_sel_o = 2'b11;
      if (bsz)          wb_dat_o = {wdat[7:0], wdat[7:0]};
      else if (!adr[0]) wb_dat_o = wdat;
      else if (hi_ph)   wb_dat_o = {8'h00, wdat[15:8]};
      else              wb_dat_o = {wdat[7:0], 8'h00};
    end
  end

endmodule
